blk_avg_acc: RTL and testbench
==============================

Name: blk_avg_acc

Overview:
- Coherent block averager for the sounder RX chain. It sums M consecutive blocks of L input beats, element by element.
- The sum is then scaled by 2^-K with rounding and saturation, and the averaged block is emitted.
- Successor to the current averager:
  - lane count is generic;
  - accumulation is done at full precision before scaling instead of pre-shifting;
  - config is latched per round;
  - adds end-of-block marking, an overflow flag and a synchronous clear.
- Sits between the correlator output and the RFNoC output FIFO.

Parameters:
- NIPC, 1, complex samples per beat (any value ≥1).
- SWIDTH, 16, width of each I and Q component (signed).
- ACC_W, 24, accumulator width per component (≥ SWIDTH+8).
- AWIDTH, 10, block-length address width; max L = 2^AWIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort of the current round; flushes the pipeline and clears ovf.
- en  in  1  input qualifier; a beat is accepted when vin&en.
- din  in  2*SWIDTH*NIPC  lane n packed as {I,Q} at bits [2*SWIDTH*(n+1)-1 : 2*SWIDTH*n], I in the upper half.
- vin  in  1  input valid.
- l  in  AWIDTH+1  block length in beats.
- m  in  9  number of blocks averaged.
- k  in  4  right shift applied to the sum.
- dout  out  2*SWIDTH*NIPC  averaged output, same packing as din.
- vout  out  1  output valid.
- eob  out  1  qualifies the last beat of an output block.
- ovf  out  1  sticky saturation flag.

Behaviour:
- Reset (async, and also on clear): vout=0, eob=0, ovf=0 (clear also clears ovf), dout=0, beat counter=0, round counter=0, pipeline valids=0.
- Config latch:
  - l, m, k are sampled when the first beat of a round is accepted; mid-round changes are ignored.
  - Effective L = max(l, 4); l≥2^AWIDTH clamps to 2^AWIDTH.
  - Effective M = max(m, 1), M ≤ 256.
- Counters:
  - The beat counter b runs 0..L-1 on each accepted beat.
  - When it wraps, the block counter r increments, over 0..M-1.
  - When r=M-1 and b=L-1 both wrap, the round ends and the next accepted beat starts a new round.
- Accumulation (per lane, per component):
  - Each input is sign-extended to ACC_W.
  - r=0: acc[b] = x.
  - 0<r<M-1: acc[b] = acc[b] + x.
  - r=M-1: s = acc[b] + x (or s = x when M=1), and the result is emitted instead of stored.
  - Storage is one simple dual-port RAM per lane, L deep × 2*ACC_W.
  - Gaps (vin or en low) stall nothing; only accepted beats advance the counters.
- Scaling:
  - y = (s + 2^(K-1)) >>> K when K>0, arithmetic; y = s when K=0.
  - y is saturated to [-2^(SWIDTH-1), 2^(SWIDTH-1)-1].
  - Any saturation sets ovf, which stays set until rst or clear.
- Pipeline:
  - Fixed latency of 3 cycles: a beat accepted at edge t appears on vout/dout at edge t+3.
  - Stage 1 registers the input and issues the RAM read at b.
  - Stage 2 performs the add.
  - Stage 3 performs round/saturate, drives the output register and performs the RAM write.
  - With L≥4, a read never hits an unwritten address, so no forwarding is required.
- Output:
  - vout=1 for exactly one cycle per beat of round r=M-1.
  - eob=vout on the beat where b=L-1.
  - dout holds its value when vout=0.
- Clear mid-round: partial sums are discarded and in-flight beats are dropped (no vout). The next accepted beat is b=0, r=0 and re-latches config.
- Reset mid-round: same result as clear, applied asynchronously.
- clear and vin&en in the same cycle: clear wins and the beat is dropped.

Test Plan:
- Pass-through, L=4, M=1, K=0, NIPC=1, din I=100 Q=-100 → vout on 4 consecutive beats, 3 cycles after each input, dout=din, eob on the 4th beat.
- Average, L=8, M=4, K=2, constant I=1000 Q=-1000 → 8 output beats only after the 4th block; I=1000, Q=-1000; eob on beat 8; ovf=0.
- Rounding: M=2, K=1, samples 3 then 0 → I=2; samples -3 then 0 → I=-1 (round half up).
- Saturation: M=4, K=0, I=30000 → I=32767, ovf=1; ovf stays 1 until clear.
- Config change and gaps: start M=2, switch m=4 after the first beat, random vin gaps → output after 2 blocks, and the next round uses M=4.
- Clear and reset mid-round, with NIPC=2 and lanes distinct: clear asserted on block 2 → no vout from the aborted round, next round correct. Async rst pulse mid-beat behaves the same.

Source files
------------

// File: rtl/blk_avg_acc.sv
// Coherent block averager: sums M blocks of L beats element by element at full
// precision, then rounds, shifts by K and saturates into the output stream.
module blk_avg_acc #(
    parameter int NIPC   = 1,
    parameter int SWIDTH = 16,
    parameter int ACC_W  = 24,
    parameter int AWIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic [2*SWIDTH*NIPC-1:0] din,
    input  logic                     vin,
    input  logic [AWIDTH:0]          l,
    input  logic [8:0]               m,
    input  logic [3:0]               k,
    output logic [2*SWIDTH*NIPC-1:0] dout,
    output logic                     vout,
    output logic                     eob,
    output logic                     ovf
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam int AW2   = 2 * ACC_W;
    localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W-SWIDTH+2){1'b0}}, {(SWIDTH-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_LO = {{(ACC_W-SWIDTH+2){1'b1}}, {(SWIDTH-1){1'b0}}};

    // Returns {saturated, y}: y = (s + 2^(sh-1)) >>> sh, clipped to SWIDTH bits.
    function automatic logic [SWIDTH:0] rnd_sat(input logic [ACC_W-1:0] s, input logic [3:0] sh);
        logic signed [ACC_W:0] t;
        logic [SWIDTH:0]       res;
        t = {s[ACC_W-1], s};
        if (sh != 4'd0)
            t = t + ((ACC_W+1)'(1) << (sh - 4'd1));
        t = t >>> sh;
        if (t > SAT_HI)
            res = {1'b1, SAT_HI[SWIDTH-1:0]};
        else if (t < SAT_LO)
            res = {1'b1, SAT_LO[SWIDTH-1:0]};
        else
            res = {1'b0, t[SWIDTH-1:0]};
        return res;
    endfunction

    logic                          accept, first;
    logic [AWIDTH-1:0]             b_cnt, l_q, l_new, l_cur;
    logic [7:0]                    r_cnt, m_q, m_new, m_cur;
    logic [3:0]                    k_q, k_cur;

    logic                          v1, v2, v3;
    logic                          first1, first2;
    logic                          last1, last2, last3;
    logic                          eob1, eob2, eob3;
    logic [3:0]                    k1, k2, k3;
    logic [AWIDTH-1:0]             b1, b2, b3;
    logic [NIPC-1:0][2*SWIDTH-1:0] x1, x2;
    logic [NIPC-1:0][AW2-1:0]      rd2, sum2, sum3;
    logic [NIPC-1:0][2*SWIDTH-1:0] y3;
    logic [SWIDTH:0]               ri, rq;
    logic                          sat_any;
    logic [AW2-1:0]                mem [NIPC][DEPTH];

    assign accept = vin & en & ~clear;
    assign first  = (b_cnt == '0) && (r_cnt == '0);

    // Effective config: L in [4, 2^AWIDTH], M in [1, 256], held as L-1 / M-1.
    // NOTE: every combinational output gets a default on every path so no latch is inferred.
    always_comb begin
        if (l[AWIDTH])
            l_new = '1;
        else if (l[AWIDTH-1:0] < AWIDTH'(4))
            l_new = AWIDTH'(3);
        else
            l_new = l[AWIDTH-1:0] - 1'b1;

        if (m[8])
            m_new = 8'hff;
        else if (m[7:0] == 8'd0)
            m_new = 8'd0;
        else
            m_new = m[7:0] - 1'b1;

        l_cur = first ? l_new : l_q;
        m_cur = first ? m_new : m_q;
        k_cur = first ? k     : k_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_cnt <= '0;  r_cnt <= '0;
            l_q   <= '0;  m_q   <= '0;  k_q <= '0;
            v1 <= 1'b0;   v2 <= 1'b0;   v3  <= 1'b0;
            first1 <= 1'b0; first2 <= 1'b0;
            last1  <= 1'b0; last2  <= 1'b0; last3 <= 1'b0;
            eob1   <= 1'b0; eob2   <= 1'b0; eob3  <= 1'b0;
            k1 <= '0; k2 <= '0; k3 <= '0;
            b1 <= '0; b2 <= '0; b3 <= '0;
            vout <= 1'b0; eob <= 1'b0; ovf <= 1'b0; dout <= '0;
        end else if (clear) begin
            b_cnt <= '0;  r_cnt <= '0;
            v1 <= 1'b0;   v2 <= 1'b0;   v3 <= 1'b0;
            vout <= 1'b0; eob <= 1'b0; ovf <= 1'b0; dout <= '0;
        end else begin
            if (accept) begin
                if (first) begin
                    l_q <= l_new;
                    m_q <= m_new;
                    k_q <= k;
                end
                if (b_cnt == l_cur) begin
                    b_cnt <= '0;
                    r_cnt <= (r_cnt == m_cur) ? 8'd0 : r_cnt + 1'b1;
                end else begin
                    b_cnt <= b_cnt + 1'b1;
                end
            end

            // Stage 1: capture beat and its position within the round.
            v1     <= accept;
            first1 <= (r_cnt == 8'd0);
            last1  <= (r_cnt == m_cur);
            eob1   <= (b_cnt == l_cur);
            k1     <= k_cur;
            b1     <= b_cnt;

            // Stage 2: RAM data arrives, add.
            v2 <= v1; first2 <= first1; last2 <= last1; eob2 <= eob1; k2 <= k1; b2 <= b1;

            // Stage 3: round/saturate.
            v3 <= v2; last3 <= last2; eob3 <= eob2; k3 <= k2; b3 <= b2;

            vout <= v3 & last3;
            eob  <= v3 & last3 & eob3;
            if (v3 && last3) begin
                dout <= y3;
                if (sat_any)
                    ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        x1   <= din;
        x2   <= x1;
        sum3 <= sum2;
    end

    // NOTE: the accumulator RAM has no reset; r=0 overwrites rather than reads stale contents.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NIPC; n++) begin
            if (v3 && !last3 && !clear)
                mem[n][b3] <= sum3[n];
            rd2[n] <= mem[n][b1];
        end
    end

    always_comb begin
        sum2 = '0;
        for (int n = 0; n < NIPC; n++) begin
            if (first2) begin
                sum2[n][AW2-1:ACC_W] = {{(ACC_W-SWIDTH){x2[n][2*SWIDTH-1]}}, x2[n][2*SWIDTH-1:SWIDTH]};
                sum2[n][ACC_W-1:0]   = {{(ACC_W-SWIDTH){x2[n][SWIDTH-1]}}, x2[n][SWIDTH-1:0]};
            end else begin
                sum2[n][AW2-1:ACC_W] = rd2[n][AW2-1:ACC_W]
                    + {{(ACC_W-SWIDTH){x2[n][2*SWIDTH-1]}}, x2[n][2*SWIDTH-1:SWIDTH]};
                sum2[n][ACC_W-1:0]   = rd2[n][ACC_W-1:0]
                    + {{(ACC_W-SWIDTH){x2[n][SWIDTH-1]}}, x2[n][SWIDTH-1:0]};
            end
        end
    end

    always_comb begin
        y3      = '0;
        sat_any = 1'b0;
        ri      = '0;
        rq      = '0;
        for (int n = 0; n < NIPC; n++) begin
            ri      = rnd_sat(sum3[n][AW2-1:ACC_W], k3);
            rq      = rnd_sat(sum3[n][ACC_W-1:0], k3);
            y3[n]   = {ri[SWIDTH-1:0], rq[SWIDTH-1:0]};
            sat_any = sat_any | ri[SWIDTH] | rq[SWIDTH];
        end
    end

endmodule

// File: tb/tb_blk_avg_acc.sv
// Scoreboard bench for blk_avg_acc: directed rounds push hand-computed results,
// a negedge monitor pops them whenever vout is seen and checks data, eob and latency.
module tb_blk_avg_acc;

    localparam int NIPC   = 2;
    localparam int SWIDTH = 16;
    localparam int ACC_W  = 24;
    localparam int AWIDTH = 4;
    localparam int DW     = 2 * SWIDTH * NIPC;

    logic              clk = 1'b0;
    logic              rst, clear, en, vin;
    logic [DW-1:0]     din, dout;
    logic [AWIDTH:0]   l;
    logic [8:0]        m;
    logic [3:0]        k;
    logic              vout, eob, ovf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
        logic          e;
    } exp_t;
    exp_t sbq[$];

    blk_avg_acc #(.NIPC(NIPC), .SWIDTH(SWIDTH), .ACC_W(ACC_W), .AWIDTH(AWIDTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .en(en), .din(din), .vin(vin),
        .l(l), .m(m), .k(k), .dout(dout), .vout(vout), .eob(eob), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d outputs pending", sbq.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Lane 1 occupies the upper half of the beat.
    function automatic logic [DW-1:0] pk(input int i0, input int q0, input int i1, input int q1);
        return {SWIDTH'(i1), SWIDTH'(q1), SWIDTH'(i0), SWIDTH'(q0)};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (vout === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_vout @cycle %0d: dout=%h eob=%b", cyc, dout, eob);
                end else begin
                    exp_t x;
                    x = sbq.pop_front();
                    check("dout", 64'(dout), 64'(x.d));
                    check("eob", 64'(eob), 64'(x.e));
                    check("latency", 64'(cyc), 64'(x.due));
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                exp_t x;
                x = sbq.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_vout @cycle %0d: expected dout=%h due %0d", cyc, x.d, x.due);
            end
        end
    end

    task automatic cfg(input logic [AWIDTH:0] nl, input logic [8:0] nm, input logic [3:0] nk);
        l = nl; m = nm; k = nk;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic want, input logic [DW-1:0] ed, input logic ee);
        vin = 1'b1; en = 1'b1; din = d;
        @(posedge clk); #1;
        vin = 1'b0;
        if (want) sbq.push_back('{due: cyc + 3, d: ed, e: ee});
    endtask

    task automatic idle(input int n);
        vin = 1'b0; en = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Non-accepted cycles: alternately vin low and en low, with junk data.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            vin = i[0]; en = ~i[0]; din = pk(999, 999, 999, 999);
            @(posedge clk); #1;
        end
        vin = 1'b0; en = 1'b1;
    endtask

    initial begin
        int i0a[4], i1a[4], ei0[4], ei1[4];
        rst = 1'b1; clear = 1'b0; en = 1'b1; vin = 1'b0; din = '0;
        cfg(5'd4, 9'd1, 4'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_vout", 64'(vout), 64'd0);
        check("rst_eob",  64'(eob),  64'd0);
        check("rst_ovf",  64'(ovf),  64'd0);
        check("rst_dout", 64'(dout), 64'd0);

        // Pass-through L=4, M=1, K=0.
        cfg(5'd4, 9'd1, 4'd0);
        for (int b = 0; b < 4; b++)
            beat(pk(100, -100, b + 1, -(b + 1)), 1'b1, pk(100, -100, b + 1, -(b + 1)), b == 3);
        idle(1);

        // l=0 and m=0 behave as L=4, M=1.
        cfg(5'd0, 9'd0, 4'd0);
        for (int b = 0; b < 4; b++)
            beat(pk(-7, 8, 200, -200), 1'b1, pk(-7, 8, 200, -200), b == 3);

        // l=20 exceeds 2^AWIDTH and clamps to L=16.
        cfg(5'd20, 9'd1, 4'd0);
        for (int b = 0; b < 16; b++)
            beat(pk(b, -b, 0, 1), 1'b1, pk(b, -b, 0, 1), b == 15);
        idle(4);

        // Average L=8, M=4, K=2: (4x + 2) >>> 2 = x for integer x.
        cfg(5'd8, 9'd4, 4'd2);
        for (int r = 0; r < 4; r++)
            for (int b = 0; b < 8; b++)
                beat(pk(1000, -1000, 500 + b, -b), r == 3, pk(1000, -1000, 500 + b, -b), b == 7);
        idle(5);
        check("avg_ovf", 64'(ovf), 64'd0);

        // Rounding M=2, K=1: 3->2, -3->-1, 5->3, -5->-2; lane1 1->1, -1->0, 7->4, 0->0.
        i0a = '{3, -3, 5, -5};  ei0 = '{2, -1, 3, -2};
        i1a = '{1, -1, 7, 0};   ei1 = '{1, 0, 4, 0};
        cfg(5'd4, 9'd2, 4'd1);
        for (int b = 0; b < 4; b++) beat(pk(i0a[b], 0, i1a[b], 2), 1'b0, '0, 1'b0);
        for (int b = 0; b < 4; b++) beat(pk(0, 0, 0, 2), 1'b1, pk(ei0[b], 0, ei1[b], 2), b == 3);
        idle(5);

        // Saturation M=4, K=0: 120000 -> 32767, -120000 -> -32768.
        cfg(5'd4, 9'd4, 4'd0);
        for (int r = 0; r < 4; r++)
            for (int b = 0; b < 4; b++)
                beat(pk(30000, -30000, 1, 1), r == 3, pk(32767, -32768, 4, 4), b == 3);
        idle(5);
        check("sat_ovf_set", 64'(ovf), 64'd1);
        cfg(5'd4, 9'd1, 4'd0);
        for (int b = 0; b < 4; b++) beat(pk(1, 2, 3, 4), 1'b1, pk(1, 2, 3, 4), b == 3);
        idle(5);
        check("sat_ovf_sticky", 64'(ovf), 64'd1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_ovf",  64'(ovf),  64'd0);
        check("clear_dout", 64'(dout), 64'd0);
        check("clear_vout", 64'(vout), 64'd0);

        // Mid-round m change is ignored (M=2 holds); the next round picks up M=4.
        cfg(5'd4, 9'd2, 4'd0);
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < 4; b++) begin
                gap($urandom_range(0, 3));
                beat(pk(b + 1, -1, 100, 0), r == 1, pk(2 * (b + 1), -2, 200, 0), b == 3);
                if (r == 0 && b == 0) m = 9'd4;
            end
        for (int r = 0; r < 4; r++)
            for (int b = 0; b < 4; b++) begin
                gap($urandom_range(0, 3));
                beat(pk(b + 1, -1, 100, 0), r == 3, pk(4 * (b + 1), -4, 400, 0), b == 3);
                if (r == 0 && b == 0) m = 9'd1;
            end
        idle(5);

        // Clear during the last block drops in-flight beats; a beat coincident with clear is lost.
        cfg(5'd4, 9'd2, 4'd0);
        for (int b = 0; b < 4; b++) beat(pk(50, 50, 60, 60), 1'b0, '0, 1'b0);
        for (int b = 0; b < 2; b++) beat(pk(50, 50, 60, 60), 1'b0, '0, 1'b0);
        vin = 1'b1; en = 1'b1; clear = 1'b1; din = pk(50, 50, 60, 60);
        @(posedge clk); #1;
        clear = 1'b0; vin = 1'b0;
        idle(6);
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < 4; b++)
                beat(pk(1, 2, 3, 4), r == 1, pk(2, 4, 6, 8), b == 3);
        idle(5);

        // Asynchronous reset pulse mid-cycle during the last block.
        for (int b = 0; b < 4; b++) beat(pk(70, 70, 80, 80), 1'b0, '0, 1'b0);
        beat(pk(70, 70, 80, 80), 1'b0, '0, 1'b0);
        #3 rst = 1'b1;
        #1 check("async_rst_vout", 64'(vout), 64'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        idle(5);
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < 4; b++)
                beat(pk(5, -5, -6, 6), r == 1, pk(10, -10, -12, 12), b == 3);

        idle(10);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
